// File: rtl/shift_add_mult_8.sv
// Sequential 8x8 unsigned shift-add multiplier: 8 cycles start-to-done, one product per 9 cycles.
// Starts arriving while busy are dropped; a start on the done cycle's closing edge is taken.
module ripple_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic c;

    always_comb begin
        c = cin;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module shift_add_mult_8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    ripple_adder_8 u_adder (
        .a    (acc_hi_q),
        .b    (m_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d      = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d   = DONE;
                    product_d = {acc_hi_d, acc_lo_d};
                end
            end
            DONE: begin
                // The closing edge of DONE is already an idle sampling point, giving 9-cycle throughput.
                state_d = IDLE;
                if (start) begin
                    m_d      = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
endmodule
